bubble_outbuf_loader: RTL and testbench
=======================================

# bubble_outbuf_loader

Write-side producer for the bubble output buffer. Accepts a byte stream (bootloader or page image) over a valid/ready handshake and serializes it MSB-first into single-bit writes on the OUTBUFWADDR/OUTBUFWCLK/OUTBUFWDATA bus. Consecutive bits alternate between the DOUT0 and DOUT1 channels. It sits between the storage/fetch logic and the bubble interface that replays the buffer onto DOUT0/DOUT1.

## Interface
- PAGE_BASE, 14342: first write address for page loads (buffer line 7171, channel 0).
- BOOT_BASE, 4106: first write address for boot loads (buffer line 2053, channel 0).
- PAGE_BYTES, 128: bytes per page load.
- BOOT_BYTES, 480: bytes per boot load.

Ports:
- MCLK  in  1  48 MHz clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  single-cycle load request; sampled only in IDLE.
- MODE  in  1  sampled with START: 0 = page load, 1 = boot load.
- BYTEDATA  in  8  source byte.
- BYTEVALID  in  1  BYTEDATA is valid.
- BYTEREADY  out  1  loader accepts a byte this cycle.
- OUTBUFWADDR  out  15  write address; bit 0 selects the channel (0 = DOUT0, 1 = DOUT1), bits [13:1] are the buffer line.
- OUTBUFWCLK  out  1  write strobe; the buffer captures data on its rising edge.
- OUTBUFWDATA  out  1  write data bit.
- BUSY  out  1  a load is in progress.
- DONE  out  1  one-cycle pulse when the final bit has been strobed.

## Operation
- FSM states: IDLE, WAIT_BYTE, SETUP, STROBE, FINISH.
- **IDLE**
  - START=1 latches MODE, loads base address and byte count from the parameters, clears the bit index → WAIT_BYTE.
  - START=0 → stay in IDLE.
- **WAIT_BYTE**
  - BYTEREADY=1.
  - On BYTEVALID=1, latch BYTEDATA into the shift register, set bit index to 7 → SETUP.
  - Otherwise stay; stalls of any length are legal.
- **SETUP**
  - OUTBUFWADDR = base + 8·byte_idx + (7 − bit index).
  - OUTBUFWDATA = shift[7].
  - OUTBUFWCLK=0.
  - → STROBE.
- **STROBE**
  - OUTBUFWCLK=1; address and data held unchanged.
  - If bit index ≠ 0: shift left, decrement bit index → SETUP.
  - Else, if this is the last byte → FINISH.
  - Else increment byte_idx → WAIT_BYTE.
- **FINISH**
  - DONE=1 for one cycle → IDLE.
- Address arithmetic:
  - 15-bit unsigned, no wrap.
  - Page load covers 14342..15365 (buffer lines 7171..7682, both channels).
  - Boot load covers 4106..7945 (buffer lines 2053..3972).
- Even bit positions go to DOUT0 and odd to DOUT1, so byte bit 7 → DOUT0, bit 6 → DOUT1, and so on.
- The loader writes stored polarity: it never inverts data.
- START in any state other than IDLE is ignored.
- BYTEVALID outside WAIT_BYTE is ignored; no byte is consumed.

## Timing
- Reset values:
  - BYTEREADY=0, OUTBUFWADDR=0, OUTBUFWCLK=0, OUTBUFWDATA=0, BUSY=0, DONE=0.
  - State IDLE.
- RESET mid-load: on the next edge the FSM returns to IDLE and all outputs take their reset values, including OUTBUFWCLK forced low. A partial image is left in the buffer with no cleanup.
- START at edge t: BUSY=1 and BYTEREADY=1 from t+1.
- Handshake: a byte transfers on an edge where BYTEREADY && BYTEVALID. BYTEREADY drops on the following cycle.
- Per-bit write:
  - SETUP cycle, then STROBE cycle: 2 cycles per bit, 16 cycles per byte.
  - OUTBUFWCLK rises one cycle after address/data become stable, and they stay stable through the high phase. This gives one full cycle of setup and hold.
- Throughput with BYTEVALID held high: 17 cycles per byte.
  - Page load: START→DONE = 1 + 128·17 = 2177 cycles.
  - Boot load: 1 + 480·17 = 8161 cycles.
- BUSY is 1 from START+1 through the FINISH cycle inclusive; it falls together with the return to IDLE.
- DONE is asserted only in FINISH. BUSY=1 during that cycle.
- START in the same cycle that FINISH exits is ignored; a new load needs START while in IDLE.

## Test plan
- Page load, MODE=0, bytes 0x00..0x7F streamed with no stalls → 1024 strobes, first at address 14342, last at 15365; DONE in cycle 2177; buffer line 7171 holds D0=0, D1=0 (byte 0x00 bits 7,6).
- Byte 0xA5 as first page byte → writes at 14342..14349 with data 1,0,1,0,0,1,0,1; each address stable in the SETUP cycle and the STROBE cycle.
- Boot load, MODE=1, 480 bytes of 0xFF → 3840 strobes covering 4106..7945, all data 1; BUSY high for 8161 cycles.
- BYTEVALID low for 5 cycles before byte 3 → BYTEREADY held high the whole time, no OUTBUFWCLK edges during the stall, addresses continue at 14342+24.
- RESET asserted mid-byte while in STROBE → next cycle OUTBUFWCLK=0, BUSY=0, BYTEREADY=0; a subsequent START restarts at the base address.
- START pulsed again mid-load with MODE flipped → ignored; the load completes with the original mode and byte count.

Source files
------------

// File: rtl/bubble_outbuf_loader_if.sv
// Byte-stream handshake plus single-bit output-buffer write bus for the bubble outbuf loader.
// master = upstream fetch logic / buffer side; slave = the loader itself.
interface bubble_outbuf_loader_if;
    logic        start;
    logic        mode;
    logic [7:0]  bytedata;
    logic        bytevalid;
    logic        byteready;
    logic [14:0] outbufwaddr;
    logic        outbufwclk;
    logic        outbufwdata;
    logic        busy;
    logic        done;

    modport master (
        output start, mode, bytedata, bytevalid,
        input  byteready, outbufwaddr, outbufwclk, outbufwdata, busy, done
    );

    modport slave (
        input  start, mode, bytedata, bytevalid,
        output byteready, outbufwaddr, outbufwclk, outbufwdata, busy, done
    );
endinterface

// File: rtl/bubble_outbuf_loader.sv
// Serializes a page or boot byte image MSB-first into single-bit output-buffer writes,
// alternating DOUT0/DOUT1 through address bit 0, with a SETUP/STROBE pair per bit.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | no load; waits for START, latches base address and byte count
// S_WAIT_BYTE | BYTEREADY high; waits for the next source byte
// S_SETUP     | address/data driven, write strobe low
// S_STROBE    | write strobe high, address/data held
// S_FINISH    | DONE pulse, then back to idle
module bubble_outbuf_loader #(
    parameter logic [14:0] PAGE_BASE  = 15'd14342,
    parameter logic [14:0] BOOT_BASE  = 15'd4106,
    parameter int unsigned PAGE_BYTES = 128,
    parameter int unsigned BOOT_BYTES = 480
) (
    input  logic                 mclk_i,
    input  logic                 reset_i,
    bubble_outbuf_loader_if.slave bus
);

    localparam logic [8:0] PAGE_LAST = 9'(PAGE_BYTES - 1);
    localparam logic [8:0] BOOT_LAST = 9'(BOOT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SETUP,
        S_STROBE,
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [8:0]  bytes_left_q, bytes_left_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;

    always_ff @(posedge mclk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            bytes_left_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            bytes_left_q <= bytes_left_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
        end
    end

    // addr_q runs ahead one bit per strobe, so it always equals base + 8*byte + (7 - bit index).
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        bytes_left_d = bytes_left_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d       = bus.mode ? BOOT_BASE : PAGE_BASE;
                    bytes_left_d = bus.mode ? BOOT_LAST : PAGE_LAST;
                    bit_idx_d    = '0;
                    state_d      = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                if (bus.bytevalid) begin
                    shift_d   = bus.bytedata;
                    bit_idx_d = 3'd7;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (bit_idx_q != 3'd0) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_idx_d = bit_idx_q - 3'd1;
                    addr_d    = addr_q + 15'd1;
                    state_d   = S_SETUP;
                end else if (bytes_left_q == 9'd0) begin
                    state_d = S_FINISH;
                end else begin
                    bytes_left_d = bytes_left_q - 9'd1;
                    addr_d       = addr_q + 15'd1;
                    state_d      = S_WAIT_BYTE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.byteready   = (state_q == S_WAIT_BYTE);
    assign bus.outbufwclk  = (state_q == S_STROBE);
    assign bus.outbufwaddr = addr_q;
    assign bus.outbufwdata = shift_q[7];
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_FINISH);

endmodule

// File: tb/tb_bubble_outbuf_loader.sv
// Randomized bench for bubble_outbuf_loader: a phase-level reference model is checked
// against the DUT every cycle, plus literal checks of addresses, data and cycle counts.
module tb_bubble_outbuf_loader;

    localparam int PAGE_BASE  = 14342;
    localparam int BOOT_BASE  = 4106;
    localparam int PAGE_BYTES = 128;
    localparam int BOOT_BYTES = 480;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bubble_outbuf_loader_if bus();

    bubble_outbuf_loader dut (
        .mclk_i (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a load is a list of bytes, each = 1 wait-or-more cycle + 16 bit cycles.
    bit       m_active = 1'b0;
    int       m_phase  = 0;   // 0 waiting for byte, 1..16 bit cycles, 17 done pulse
    int       m_ndone  = 0;
    int       m_total  = 0;
    int       m_base   = 0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active = 1'b1;
                m_base   = bus.mode ? BOOT_BASE : PAGE_BASE;
                m_total  = bus.mode ? BOOT_BYTES : PAGE_BYTES;
                m_ndone  = 0;
                m_phase  = 0;
            end
        end else if (m_phase == 0) begin
            if (bus.bytevalid) begin
                m_byte  = bus.bytedata;
                m_phase = 1;
            end
        end else if (m_phase < 16) begin
            m_phase++;
        end else if (m_phase == 16) begin
            if (m_ndone + 1 == m_total) m_phase = 17;
            else begin
                m_ndone++;
                m_phase = 0;
            end
        end else begin
            m_active = 1'b0;
        end
    end

    // Compare + record process
    bit   chk_en = 1'b0;
    int   cyc = 0, t0 = 0, done_lat = 0, busy_cnt = 0, n_strobe = 0, n_ones = 0, stall_obs = 0;
    bit   done_seen = 1'b0;
    int   s_addr [0:4095];
    logic s_data [0:4095];

    always @(negedge clk) begin
        int bi;
        cyc++;
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_active));
            chk("byteready", 32'(bus.byteready), 32'(m_active && m_phase == 0));
            chk("wclk", 32'(bus.outbufwclk),
                32'(m_active && m_phase >= 1 && m_phase <= 16 && (m_phase % 2) == 0));
            chk("done", 32'(bus.done), 32'(m_active && m_phase == 17));
            if (m_active && m_phase >= 1 && m_phase <= 16) begin
                bi = (m_phase - 1) / 2;
                chk("waddr", 32'(bus.outbufwaddr), 32'(m_base + 8 * m_ndone + bi));
                chk("wdata", 32'(bus.outbufwdata), 32'(m_byte[7 - bi]));
            end
        end
        if (bus.start === 1'b1 && !m_active) t0 = cyc;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.outbufwclk === 1'b1) begin
            if (n_strobe < 4096) begin
                s_addr[n_strobe] = int'(bus.outbufwaddr);
                s_data[n_strobe] = bus.outbufwdata;
            end
            if (bus.outbufwdata === 1'b1) n_ones++;
            n_strobe++;
        end
        if (bus.done === 1'b1) begin
            done_seen = 1'b1;
            done_lat  = cyc - t0;
        end
        if (bus.byteready === 1'b1 && bus.bytevalid === 1'b0) stall_obs++;
    end

    // Byte source driver
    logic [7:0] src_bytes [0:479];
    int src_idx = 0;
    int vmode = 0;        // 0 always valid, 1 random, 2 five-cycle stall before byte 3
    int stall_left = 5;

    initial begin : drv
        bit take;
        bus.bytevalid = 1'b0;
        bus.bytedata  = 8'h00;
        forever begin
            @(negedge clk);
            take = (bus.byteready === 1'b1) && (bus.bytevalid === 1'b1);
            if (vmode == 2 && src_idx == 3 && bus.byteready === 1'b1 && stall_left > 0)
                stall_left--;
            @(posedge clk);
            #1;
            if (take) src_idx++;
            bus.bytedata = (src_idx < 480) ? src_bytes[src_idx] : 8'h00;
            case (vmode)
                0:       bus.bytevalid = 1'b1;
                1:       bus.bytevalid = ($urandom_range(0, 3) != 0);
                default: bus.bytevalid = !(src_idx == 3 && stall_left > 0);
            endcase
        end
    end

    task automatic start_load(input logic md, input int vm);
        @(negedge clk);
        #2;
        src_idx    = 0;
        vmode      = vm;
        stall_left = 5;
        n_strobe   = 0;
        n_ones     = 0;
        busy_cnt   = 0;
        stall_obs  = 0;
        done_seen  = 1'b0;
        @(posedge clk);
        #1;
        bus.mode  = md;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20000 && !done_seen; i++) @(negedge clk);
        chk(name, 32'(done_seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a5_exp [8];
        a5_exp = '{1, 0, 1, 0, 0, 1, 0, 1};
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        for (int i = 0; i < 480; i++) src_bytes[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", 32'(bus.outbufwaddr), 32'd0);
        chk("rst_wdata", 32'(bus.outbufwdata), 32'd0);
        chk("rst_wclk", 32'(bus.outbufwclk), 32'd0);
        chk("rst_byteready", 32'(bus.byteready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Page load of 0x00..0x7F, no stalls
        for (int i = 0; i < 128; i++) src_bytes[i] = 8'(i);
        start_load(1'b0, 0);
        wait_done("page_done_timeout");
        chk("page_strobes", 32'(n_strobe), 32'd1024);
        chk("page_first_addr", 32'(s_addr[0]), 32'd14342);
        chk("page_last_addr", 32'(s_addr[1023]), 32'd15365);
        chk("page_done_cycle", 32'(done_lat), 32'd2177);
        chk("page_busy_cycles", 32'(busy_cnt), 32'd2177);
        chk("page_line0_d0", 32'(s_data[0]), 32'd0);
        chk("page_line0_d1", 32'(s_data[1]), 32'd0);

        // 0xA5 first byte, random rest, random BYTEVALID
        src_bytes[0] = 8'hA5;
        for (int i = 1; i < 128; i++) src_bytes[i] = 8'($urandom_range(0, 255));
        start_load(1'b0, 1);
        wait_done("a5_done_timeout");
        for (int i = 0; i < 8; i++) begin
            chk("a5_data", 32'(s_data[i]), 32'(a5_exp[i]));
            chk("a5_addr", 32'(s_addr[i]), 32'(14342 + i));
        end

        // Boot load of 480 x 0xFF
        for (int i = 0; i < 480; i++) src_bytes[i] = 8'hFF;
        start_load(1'b1, 0);
        wait_done("boot_done_timeout");
        chk("boot_strobes", 32'(n_strobe), 32'd3840);
        chk("boot_first_addr", 32'(s_addr[0]), 32'd4106);
        chk("boot_last_addr", 32'(s_addr[3839]), 32'd7945);
        chk("boot_ones", 32'(n_ones), 32'd3840);
        chk("boot_busy_cycles", 32'(busy_cnt), 32'd8161);
        chk("boot_done_cycle", 32'(done_lat), 32'd8161);

        // Five-cycle stall before byte 3
        for (int i = 0; i < 128; i++) src_bytes[i] = 8'($urandom_range(0, 255));
        start_load(1'b0, 2);
        wait_done("stall_done_timeout");
        chk("stall_cycles", 32'(stall_obs), 32'd5);
        chk("stall_byte3_addr", 32'(s_addr[24]), 32'd14366);
        chk("stall_strobes", 32'(n_strobe), 32'd1024);

        // Reset in a STROBE cycle mid-byte, then restart
        start_load(1'b0, 1);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 5000 && !hit; i++) begin
                @(negedge clk);
                hit = (n_strobe >= 21) && (bus.outbufwclk === 1'b1);
            end
            chk("rst_mid_reach", 32'(hit), 32'd1);
        end
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_wclk", 32'(bus.outbufwclk), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_byteready", 32'(bus.byteready), 32'd0);
        chk("rst_mid_addr", 32'(bus.outbufwaddr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_load(1'b0, 1);
        wait_done("restart_done_timeout");
        chk("restart_first_addr", 32'(s_addr[0]), 32'd14342);
        chk("restart_strobes", 32'(n_strobe), 32'd1024);

        // START with MODE flipped mid-load is ignored
        start_load(1'b0, 1);
        repeat (300) @(posedge clk);
        #1;
        bus.mode  = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        wait_done("restart_ign_done_timeout");
        chk("ign_strobes", 32'(n_strobe), 32'd1024);
        chk("ign_last_addr", 32'(s_addr[1023]), 32'd15365);

        // START during the FINISH cycle is ignored
        start_load(1'b0, 0);
        for (int i = 0; i < 5000 && bus.done !== 1'b1; i++) @(negedge clk);
        chk("fin_done_seen", 32'(bus.done), 32'd1);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("fin_start_ignored", 32'(bus.busy), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
